uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 9_600, line rate in bits/s.
REQ-003 SHALL have parameter WORDSZ, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter DEPTH, default 4, FIFO entries, power of 2, minimum 2.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port RXD_PIN, input, 1 bit: asynchronous UART line, idle high.
REQ-009 SHALL have port EN, input, 1 bit: receive enable (slide switch).
REQ-010 SHALL have port RD, input, 1 bit: pop FIFO head.
REQ-011 SHALL have port DATA, output, WORDSZ bits: FIFO head, first-word fall-through.
REQ-012 SHALL have port VALID, output, 1 bit: FIFO not empty.
REQ-013 SHALL have port FULL, output, 1 bit: FIFO full.
REQ-014 SHALL have port COUNT, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-015 SHALL have port ERR, output, 3 bits: sticky {OVERRUN, PARITY_ERR, FRAME_ERR}.
REQ-016 SHALL have port CLR_ERR, input, 1 bit: clears ERR on the next clock.
REQ-017 SHALL have port STATE, output, 4 bits: receiver FSM encoding, for debug.

Function
REQ-018 SHALL pass RXD_PIN through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-019 SHALL generate a 16x oversample tick every CLK_FREQ/(BAUD*16) clocks, using integer truncation; the divider SHALL restart on start-edge detection.
REQ-020 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-021 IDLE: a falling edge on the synchronized line while EN=1 SHALL move the FSM to START.
REQ-022 START: the line SHALL be sampled after 8 ticks; if low, go to DATA; if high (glitch), return to IDLE with no error.
REQ-023 DATA: WORDSZ bits SHALL be sampled every 16 ticks, LSB first; afterwards go to PARITY if PARITY!=0, else STOP.
REQ-024 PARITY: one bit SHALL be sampled 16 ticks later; a mismatch SHALL set PARITY_ERR and discard the frame.
REQ-025 STOP: the line SHALL be sampled 16 ticks later.
- Sample high: push the word unless it was discarded; go to IDLE.
- Sample low: set FRAME_ERR, discard the word, go to WAIT_HIGH.
REQ-026 WAIT_HIGH: the FSM SHALL stay until the line is sampled high, then go to IDLE; this prevents a break condition from being read as frames.
REQ-027 A push SHALL make the word visible on DATA, with VALID=1, on the clock after the stop sample.
REQ-028 A push when FULL=1 and RD=0 SHALL drop the word and set OVERRUN; FIFO contents SHALL be unchanged.
REQ-029 Simultaneous push and RD with FULL=1 SHALL pop the head and accept the push; COUNT SHALL remain DEPTH.
REQ-030 RD with VALID=0 SHALL be ignored; there is no underflow and no error.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH.
REQ-032 COUNT SHALL change by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-033 EN deasserted in any non-IDLE state SHALL return the FSM to IDLE within 1 clock.
- The partial frame SHALL be discarded with no error.
- FIFO contents SHALL be retained.
REQ-034 CLR_ERR SHALL clear ERR; an error event in the same cycle as CLR_ERR SHALL win (set dominates).

Reset
REQ-035 RST_N low SHALL asynchronously put the FSM in IDLE and clear the divider, synchronizer (to 1), FIFO pointers, COUNT, ERR and DATA.
REQ-036 The reset values SHALL be: VALID=0, FULL=0, COUNT=0, ERR=3'b000, DATA=0, STATE=IDLE.
REQ-037 Reset asserted mid-frame SHALL abort the frame; after release the receiver SHALL require a new falling edge.
REQ-038 RST_N release SHALL be synchronized internally (assert async, deassert sync).

Structure
REQ-039 Package uart_pkg SHALL hold the FSM state encodings (4-bit), the parity mode constants, and OVERSAMPLE=16.
REQ-040 The FIFO SHALL be a separate sub-module, sync_fifo, with parameters WIDTH and DEPTH; the receiver FSM, divider and error logic SHALL stay in uart_rx_fifo.

Verification
REQ-041 Reset release, EN=1, send 'A' (8'h41), 8N1 at BAUD -> DATA=8'h41, VALID=1, COUNT=1 one clock after the stop sample; RD pulse -> VALID=0.
REQ-042 With PARITY=2, send 8'h41 with parity bit 0 -> word stored; send 8'h41 with parity bit 1 -> ERR=3'b010, COUNT unchanged; CLR_ERR -> ERR=0.
REQ-043 Low pulse of half a bit period on RXD_PIN -> FSM returns to IDLE from START, no push, ERR=0.
REQ-044 Frame with stop bit 0, line then held low for 3 bit periods -> ERR=3'b001, no push, STATE=WAIT_HIGH until the line is high; the next frame 8'h00 is received correctly.
REQ-045 DEPTH=4, send 8'h01..8'h05 with no RD -> FULL=1, COUNT=4, ERR=3'b100, pops return 01,02,03,04; repeat with RD coincident with the 5th push -> no OVERRUN, pops return 02..05.
REQ-046 RST_N pulse low during the 4th data bit -> all outputs at reset values immediately; a subsequent full frame 8'hA5 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART receiver.
//   - 4-bit receiver FSM state encodings (also driven out on STATE)
//   - parity mode selectors and the oversampling ratio
//   - ERR bit positions and a parity-check helper
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_START     = 4'd1;
  localparam logic [3:0] ST_DATA      = 4'd2;
  localparam logic [3:0] ST_PARITY    = 4'd3;
  localparam logic [3:0] ST_STOP      = 4'd4;
  localparam logic [3:0] ST_WAIT_HIGH = 4'd5;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit positions inside ERR = {OVERRUN, PARITY_ERR, FRAME_ERR}
  localparam int ERR_FRAME   = 0;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_OVERRUN = 2;

  // True when the received parity bit disagrees with the mode.
  // data_xor is the XOR of all data bits.
  function automatic logic parity_bad(input int mode, input logic data_xor, input logic par_bit);
    if (mode == PAR_ODD) begin
      parity_bad = ~(data_xor ^ par_bit);  // total ones must be odd
    end else begin
      parity_bad = data_xor ^ par_bit;     // total ones must be even
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small first-word fall-through FIFO.
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en, wr_data  : push request and word
//   rd_en           : pop request (ignored when empty)
//   rd_data         : head word, forced to 0 while empty
//   valid, full     : not-empty / full flags
//   count           : occupancy 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != FULL_CNT) || do_rd);
    // Power-of-two depth: pointers wrap naturally
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign valid   = (count_q != '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = valid ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling UART receiver feeding a FWFT FIFO.
//   CLK, RST_N : clock; async-assert / sync-deassert active-low reset
//   RXD_PIN    : asynchronous serial line, idle high
//   EN         : receive enable; dropping it aborts a frame in progress
//   RD         : pop FIFO head
//   DATA/VALID : FIFO head word and not-empty flag
//   FULL/COUNT : FIFO full flag and occupancy
//   ERR        : sticky {OVERRUN, PARITY_ERR, FRAME_ERR}, cleared by CLR_ERR
//   STATE      : receiver FSM state, for debug
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9_600,
  parameter int WORDSZ   = 8,
  parameter int PARITY   = 0,
  parameter int DEPTH    = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     RXD_PIN,
  input  logic                     EN,
  input  logic                     RD,
  output logic [WORDSZ-1:0]        DATA,
  output logic                     VALID,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [2:0]               ERR,
  input  logic                     CLR_ERR,
  output logic [3:0]               STATE
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam int BW      = $clog2(WORDSZ);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORDSZ - 1);

  // Reset: asserts immediately, releases two clocks later on CLK
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  logic              rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [1:0]        prime_q, prime_d;
  logic [DW-1:0]     div_q, div_d;
  logic [3:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORDSZ-1:0] shift_q, shift_d;
  logic [WORDSZ-1:0] push_data_q, push_data_d;
  logic [3:0]        state_q, state_d;
  logic              discard_q, discard_d;
  logic              push_q, push_d;
  logic [2:0]        err_q, err_d, err_set;
  logic              tick, sample, fall;

  always_comb begin
    rx_meta_d = RXD_PIN;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    // Edge detection is held off until the synchronizer and rx_prev carry
    // real line values, so a line already low at reset release is not a start
    prime_d   = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    fall      = (prime_q == 2'd3) && rx_prev_q && !rx_sync_q;

    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + DW'(1);
    // Bit centres: 16th tick since the previous sample point
    sample    = tick && (tick_cnt_q == 4'd15);

    state_d     = state_q;
    tick_cnt_d  = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    discard_d   = discard_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    err_set     = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (EN && fall) begin
          state_d    = ST_START;
          div_d      = '0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          discard_d  = 1'b0;
        end
      end
      ST_START: begin
        // Middle of the start bit; a high line here was a glitch
        if (tick && tick_cnt_q == 4'd7) begin
          tick_cnt_d = '0;
          state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = {rx_sync_q, shift_q[WORDSZ-1:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          if (parity_bad(PARITY, ^shift_q, rx_sync_q)) begin
            discard_d           = 1'b1;
            err_set[ERR_PARITY] = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          if (rx_sync_q) begin
            push_d      = !discard_q;
            push_data_d = shift_q;
            state_d     = ST_IDLE;
          end else begin
            err_set[ERR_FRAME] = 1'b1;
            state_d            = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // Ride out a break without decoding it as frames
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!EN && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end

    // Push lands while full and nobody pops: word is lost
    err_set[ERR_OVERRUN] = push_q && FULL && !RD;
    // Set dominates clear
    err_d = (CLR_ERR ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      prime_q     <= 2'd0;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_data_q <= '0;
      state_q     <= ST_IDLE;
      discard_q   <= 1'b0;
      push_q      <= 1'b0;
      err_q       <= 3'b000;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      prime_q     <= prime_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_data_q <= push_data_d;
      state_q     <= state_d;
      discard_q   <= discard_d;
      push_q      <= push_d;
      err_q       <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORDSZ),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (rst_int_n),
    .wr_en   (push_q),
    .wr_data (push_data_q),
    .rd_en   (RD),
    .rd_data (DATA),
    .valid   (VALID),
    .full    (FULL),
    .count   (COUNT)
  );

  assign ERR   = err_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo.
// Two instances: dut_a (8N1) and dut_p (8E1). 640 kHz / 10 kBd gives a
// 4-clock tick and a 64-clock bit period.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       rxd_a = 1'b1, rxd_p = 1'b1;
  logic       rd_a = 1'b0, rd_p = 1'b0;
  logic       clr_a = 1'b0, clr_p = 1'b0;
  logic [7:0] data_a, data_p;
  logic       valid_a, valid_p, full_a, full_p;
  logic [2:0] count_a, count_p, err_a, err_p;
  logic [3:0] state_a, state_p;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(640_000), .BAUD(10_000), .WORDSZ(8), .PARITY(0), .DEPTH(4)) dut_a (
    .CLK(clk), .RST_N(rst_n), .RXD_PIN(rxd_a), .EN(en), .RD(rd_a),
    .DATA(data_a), .VALID(valid_a), .FULL(full_a), .COUNT(count_a),
    .ERR(err_a), .CLR_ERR(clr_a), .STATE(state_a));

  uart_rx_fifo #(.CLK_FREQ(640_000), .BAUD(10_000), .WORDSZ(8), .PARITY(2), .DEPTH(4)) dut_p (
    .CLK(clk), .RST_N(rst_n), .RXD_PIN(rxd_p), .EN(en), .RD(rd_p),
    .DATA(data_p), .VALID(valid_p), .FULL(full_p), .COUNT(count_p),
    .ERR(err_p), .CLR_ERR(clr_p), .STATE(state_p));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rxd_p = v;
    else     rxd_a = v;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, optional parity, stop; one idle bit after a good stop
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input bit par, input bit stop);
    set_line(sel, 1'b0); wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]); wait_bits(1);
    end
    if (use_par) begin
      set_line(sel, par); wait_bits(1);
    end
    set_line(sel, stop); wait_bits(1);
    if (stop) wait_bits(1);
  endtask

  // Returns on the first negedge after dut_a leaves STOP (the stop-sample edge)
  task automatic wait_stop_exit(output bit ok);
    bit seen = 0;
    ok = 0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (state_a == ST_STOP) seen = 1;
    end
    for (int n = 0; n < 200 && seen && !ok; n++) begin
      @(negedge clk);
      if (state_a != ST_STOP) ok = 1;
    end
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_eq(tag, data_a, exp);
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
  endtask

  task automatic pulse_clr(input bit sel);
    if (sel) clr_p = 1'b1; else clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0; clr_p = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;

    // Reset values
    repeat (5) @(negedge clk);
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_full", full_a, 0);
    check_eq("rst_count", count_a, 0);
    check_eq("rst_err", err_a, 0);
    check_eq("rst_data", data_a, 0);
    check_eq("rst_state", state_a, ST_IDLE);
    check_eq("rst_state_p", state_p, ST_IDLE);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 'A': visible one clock after the stop sample
    fork
      send_frame(0, 8'h41, 0, 0, 1);
      begin
        wait_stop_exit(ok);
        check_eq("a_stop_exit", ok, 1);
        check_eq("a_valid_at_stop", valid_a, 0);
        @(negedge clk);
        check_eq("a_valid", valid_a, 1);
        check_eq("a_data", data_a, 8'h41);
        check_eq("a_count", count_a, 1);
      end
    join
    pop_expect("a_pop", 8'h41);
    check_eq("a_valid_after_rd", valid_a, 0);
    // RD while empty is ignored
    rd_a = 1'b1; @(negedge clk); rd_a = 1'b0;
    check_eq("empty_rd_count", count_a, 0);
    check_eq("empty_rd_err", err_a, 0);

    // Half-bit glitch
    rxd_a = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("glitch_start", state_a, ST_START);
    repeat (BIT / 2 - 10) @(negedge clk);
    rxd_a = 1'b1;
    wait_bits(1);
    check_eq("glitch_idle", state_a, ST_IDLE);
    check_eq("glitch_count", count_a, 0);
    check_eq("glitch_err", err_a, 0);

    // Framing error followed by a 3-bit break
    send_frame(0, 8'h55, 0, 0, 0);
    wait_bits(3);
    check_eq("brk_state", state_a, ST_WAIT_HIGH);
    check_eq("brk_err", err_a, 3'b001);
    check_eq("brk_count", count_a, 0);
    rxd_a = 1'b1;
    wait_bits(1);
    check_eq("brk_idle", state_a, ST_IDLE);
    pulse_clr(0);
    check_eq("brk_clr", err_a, 0);
    send_frame(0, 8'h00, 0, 0, 1);
    check_eq("brk_next_count", count_a, 1);
    pop_expect("brk_next_data", 8'h00);

    // Overrun: five words into four entries
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 0, 1);
    check_eq("ovr_full", full_a, 1);
    check_eq("ovr_count", count_a, 4);
    check_eq("ovr_err", err_a, 3'b100);
    for (int i = 1; i <= 4; i++) pop_expect("ovr_pop", 8'(i));
    check_eq("ovr_empty", valid_a, 0);
    pulse_clr(0);
    check_eq("ovr_clr", err_a, 0);

    // Pop coincident with the fifth push
    for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 0, 0, 1);
    fork
      send_frame(0, 8'h05, 0, 0, 1);
      begin
        wait_stop_exit(ok);
        check_eq("co_stop_exit", ok, 1);
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
        check_eq("co_count_kept", count_a, 4);
      end
    join
    check_eq("co_err", err_a, 0);
    check_eq("co_full", full_a, 1);
    for (int i = 2; i <= 5; i++) pop_expect("co_pop", 8'(i));

    // Reset during the 4th data bit
    send_frame(0, 8'h3C, 0, 0, 1);
    check_eq("mr_pre_count", count_a, 1);
    rxd_a = 1'b0; wait_bits(1);            // start
    rxd_a = 1'b1; wait_bits(1);            // A5 bit0
    rxd_a = 1'b0; wait_bits(1);            // bit1
    rxd_a = 1'b1; wait_bits(1);            // bit2
    rxd_a = 1'b0;                          // bit3
    repeat (BIT / 2) @(negedge clk);
    check_eq("mr_pre_state", state_a, ST_DATA);
    rst_n = 1'b0;
    #1;
    check_eq("mr_state", state_a, ST_IDLE);
    check_eq("mr_valid", valid_a, 0);
    check_eq("mr_count", count_a, 0);
    check_eq("mr_data", data_a, 0);
    check_eq("mr_err", err_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (BIT / 2 - 3) @(negedge clk);
    rxd_a = 1'b1;
    wait_bits(2);
    check_eq("mr_after_state", state_a, ST_IDLE);
    check_eq("mr_after_count", count_a, 0);
    send_frame(0, 8'hA5, 0, 0, 1);
    check_eq("mr_a5_count", count_a, 1);
    pop_expect("mr_a5_data", 8'hA5);

    // Even parity instance
    send_frame(1, 8'h41, 1, 0, 1);
    check_eq("par_ok_count", count_p, 1);
    check_eq("par_ok_data", data_p, 8'h41);
    check_eq("par_ok_err", err_p, 0);
    send_frame(1, 8'h41, 1, 1, 1);
    check_eq("par_bad_err", err_p, 3'b010);
    check_eq("par_bad_count", count_p, 1);
    pulse_clr(1);
    check_eq("par_clr", err_p, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
